// File: rtl/history_replay_pkg.sv
// Shared types and sizing helpers for the history_replay block.
package history_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        PLAY = 1'b1
    } state_t;

    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/history_replay_if.sv
// Capture/replay-request/stream bundle between history_replay and its user.
interface history_replay_if
    import history_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
);
    localparam int CW = ptr_width(DEPTH) + 1;

    logic             capture_en;
    logic [WIDTH-1:0] current_value;
    logic             replay_start;
    logic [CW-1:0]    replay_len;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_last;
    logic             busy;
    logic [CW-1:0]    count;

    modport master (
        output capture_en, current_value, replay_start, replay_len, out_ready,
        input  out_valid, out_data, out_last, busy, count
    );

    modport slave (
        input  capture_en, current_value, replay_start, replay_len, out_ready,
        output out_valid, out_data, out_last, busy, count
    );

endinterface

// File: rtl/history_replay_ram.sv
// History storage: one synchronous write port, one asynchronous read port.
module history_ram #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/history_replay.sv
// Circular sample history with oldest-first replay over a valid/ready stream.
// Optional macro HISTORY_REPLAY_CLEAR_EN: a completed replay empties the history.
module history_replay
    import history_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    history_replay_if.slave bus
);
    // state | meaning
    // IDLE  | capturing samples, waiting for replay_start
    // PLAY  | streaming the replay window; history frozen

    localparam int PW = ptr_width(DEPTH);
    localparam int CW = PW + 1;

    state_t           state;
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    beats_left;
    logic [CW-1:0]    count_q;
    logic             out_valid_q;
    logic             out_last_q;
    logic [WIDTH-1:0] out_data_q;
    logic             busy_q;

    logic [CW-1:0]    eff;
    logic [PW-1:0]    start_ptr;
    logic [PW-1:0]    rd_next;
    logic [PW-1:0]    raddr;
    logic [WIDTH-1:0] rdata;
    logic             cap_we;
    logic             handshake;

    always_comb begin
        eff = bus.replay_len;
        if (bus.replay_len == '0 || bus.replay_len > count_q) begin
            eff = count_q;
        end
    end

    // eff == DEPTH truncates to 0, so the window starts at wr_ptr (the oldest entry)
    assign start_ptr = wr_ptr - eff[PW-1:0];
    assign rd_next   = rd_ptr + PW'(1);
    assign raddr     = (state == IDLE) ? start_ptr : rd_next;
    assign cap_we    = bus.capture_en && (state == IDLE);
    assign handshake = out_valid_q && bus.out_ready;

    history_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (PW)
    ) u_ram (
        .clk   (clk),
        .we    (cap_we),
        .waddr (wr_ptr),
        .wdata (bus.current_value),
        .raddr (raddr),
        .rdata (rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            beats_left  <= '0;
            count_q     <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_data_q  <= '0;
            busy_q      <= 1'b0;
        end else begin
            if (cap_we) begin
                wr_ptr <= wr_ptr + PW'(1);
                if (count_q != CW'(DEPTH)) begin
                    count_q <= count_q + CW'(1);
                end
            end
            case (state)
                IDLE: begin
                    // the first beat is read before this edge's capture write lands
                    if (bus.replay_start && eff != '0) begin
                        rd_ptr      <= start_ptr;
                        beats_left  <= eff;
                        out_data_q  <= rdata;
                        out_valid_q <= 1'b1;
                        out_last_q  <= (eff == CW'(1));
                        busy_q      <= 1'b1;
                        state       <= PLAY;
                    end
                end
                PLAY: begin
                    if (handshake) begin
                        if (beats_left == CW'(1)) begin
                            out_valid_q <= 1'b0;
                            out_last_q  <= 1'b0;
                            busy_q      <= 1'b0;
                            state       <= IDLE;
`ifdef HISTORY_REPLAY_CLEAR_EN
                            count_q     <= '0;
`endif
                        end else begin
                            rd_ptr      <= rd_next;
                            beats_left  <= beats_left - CW'(1);
                            out_data_q  <= rdata;
                            out_last_q  <= (beats_left == CW'(2));
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_last  = out_last_q;
    assign bus.out_data  = out_data_q;
    assign bus.busy      = busy_q;
    assign bus.count     = count_q;

endmodule

// File: tb/tb_history_replay.sv
// Directed, table-driven bench for history_replay (WIDTH=8, DEPTH=16).
module tb_history_replay;

    localparam int WIDTH = 8;
    localparam int DEPTH = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    history_replay_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    history_replay #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        bit    do_reset;
        int    base;
        int    n_cap;
        int    len;
        int    exp_first;
        int    exp_n;
        int    exp_count;
        string name;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic capture(input int v);
        bus.capture_en    = 1'b1;
        bus.current_value = WIDTH'(v);
        tick();
        bus.capture_en    = 1'b0;
    endtask

    // Start a replay with out_ready held high and check the beat stream.
    task automatic replay(input string name, input int len, input int exp_first, input int exp_n);
        bus.out_ready    = 1'b1;
        bus.replay_start = 1'b1;
        bus.replay_len   = 5'(len);
        tick();
        bus.replay_start = 1'b0;
        for (int i = 0; i < exp_n; i++) begin
            chk({name, "_valid"}, 32'(bus.out_valid), 32'd1);
            chk({name, "_data"},  32'(bus.out_data),  32'(8'(exp_first + i)));
            chk({name, "_last"},  32'(bus.out_last),  32'(i == exp_n - 1));
            tick();
        end
        chk({name, "_valid_end"}, 32'(bus.out_valid), 32'd0);
        chk({name, "_busy_end"},  32'(bus.busy),      32'd0);
    endtask

    vec_t vecs[6];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.capture_en    = 1'b0;
        bus.current_value = '0;
        bus.replay_start  = 1'b0;
        bus.replay_len    = '0;
        bus.out_ready     = 1'b1;

        vecs[0] = '{1'b1, 5, 3,  0, 5,  3,  3,  "v_basic"};
        vecs[1] = '{1'b1, 1, 20, 4, 17, 4,  16, "v_wrap4"};
        vecs[2] = '{1'b0, 0, 0,  30, 5, 16, 16, "v_len30"};
        vecs[3] = '{1'b0, 0, 0,  16, 5, 16, 16, "v_len16"};
        vecs[4] = '{1'b1, 1, 2,  1, 2,  1,  2,  "v_len1"};
        vecs[5] = '{1'b0, 0, 0,  3, 1,  2,  2,  "v_len_gt"};

        #3;
        chk("rst_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_busy",  32'(bus.busy),      32'd0);
        chk("rst_count", 32'(bus.count),     32'd0);
        chk("rst_data",  32'(bus.out_data),  32'd0);
        chk("rst_last",  32'(bus.out_last),  32'd0);
        rst_n = 1'b1;
        tick();

`ifndef HISTORY_REPLAY_CLEAR_EN
        for (int v = 0; v < 6; v++) begin
            if (vecs[v].do_reset) do_reset();
            for (int k = 0; k < vecs[v].n_cap; k++) capture(vecs[v].base + k);
            replay(vecs[v].name, vecs[v].len, vecs[v].exp_first, vecs[v].exp_n);
            chk({vecs[v].name, "_count"}, 32'(bus.count), 32'(vecs[v].exp_count));
        end

        // capture and replay_start in the same cycle: new sample excluded from the window
        do_reset();
        capture(1);
        capture(2);
        bus.capture_en    = 1'b1;
        bus.current_value = 8'd99;
        bus.out_ready     = 1'b1;
        bus.replay_start  = 1'b1;
        bus.replay_len    = '0;
        tick();
        bus.capture_en    = 1'b0;
        bus.replay_start  = 1'b0;
        chk("same_d0", 32'(bus.out_data), 32'd1);
        chk("same_l0", 32'(bus.out_last), 32'd0);
        tick();
        chk("same_d1", 32'(bus.out_data), 32'd2);
        chk("same_l1", 32'(bus.out_last), 32'd1);
        tick();
        chk("same_end",   32'(bus.out_valid), 32'd0);
        chk("same_count", 32'(bus.count),     32'd3);

        // capture attempts during PLAY are ignored
        bus.out_ready     = 1'b0;
        bus.replay_start  = 1'b1;
        bus.replay_len    = 5'd1;
        tick();
        bus.replay_start  = 1'b0;
        bus.capture_en    = 1'b1;
        bus.current_value = 8'd55;
        tick();
        tick();
        bus.capture_en    = 1'b0;
        chk("play_cap_busy",  32'(bus.busy),     32'd1);
        chk("play_cap_data",  32'(bus.out_data), 32'd99);
        chk("play_cap_count", 32'(bus.count),    32'd3);
        bus.out_ready     = 1'b1;
        tick();
        chk("play_cap_end",    32'(bus.out_valid), 32'd0);
        chk("play_cap_count2", 32'(bus.count),     32'd3);
`else
        capture(3);
        capture(4);
        capture(5);
        replay("clr", 0, 3, 3);
        chk("clr_count", 32'(bus.count), 32'd0);
        replay("clr_again", 0, 0, 0);
        tick();
        chk("clr_again_valid", 32'(bus.out_valid), 32'd0);
`endif

        // backpressure: ready pattern 1,0,0,1,1 over a 3-beat replay
        begin
            int pat[5]      = '{1, 0, 0, 1, 1};
            int exp_d[5]    = '{10, 11, 11, 11, 12};
            int exp_l[5]    = '{0, 0, 0, 0, 1};
            int handshakes  = 0;
            do_reset();
            capture(10);
            capture(11);
            capture(12);
            bus.out_ready    = 1'b0;
            bus.replay_start = 1'b1;
            bus.replay_len   = 5'd3;
            tick();
            bus.replay_start = 1'b0;
            for (int i = 0; i < 5; i++) begin
                bus.out_ready = pat[i][0];
                chk("stall_valid", 32'(bus.out_valid), 32'd1);
                chk("stall_data",  32'(bus.out_data),  32'(exp_d[i]));
                chk("stall_last",  32'(bus.out_last),  32'(exp_l[i]));
                if (bus.out_valid && bus.out_ready) handshakes++;
                tick();
            end
            chk("stall_end",  32'(bus.out_valid), 32'd0);
            chk("stall_hs",   32'(handshakes),    32'd3);
            bus.out_ready = 1'b1;
        end

        // asynchronous reset mid-replay
        do_reset();
        for (int k = 1; k <= 4; k++) capture(k);
        bus.out_ready    = 1'b0;
        bus.replay_start = 1'b1;
        bus.replay_len   = '0;
        tick();
        bus.replay_start = 1'b0;
        chk("mid_valid_pre", 32'(bus.out_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(bus.out_valid), 32'd0);
        chk("mid_rst_busy",  32'(bus.busy),      32'd0);
        chk("mid_rst_count", 32'(bus.count),     32'd0);
        #1;
        rst_n = 1'b1;
        tick();
        chk("post_rst_valid", 32'(bus.out_valid), 32'd0);
        replay("empty", 0, 0, 0);
        tick();
        chk("empty_valid2", 32'(bus.out_valid), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/history_replay.md
HISTORY_REPLAY -- requirements
Module: history_replay

Interface
REQ-001 Parameter WIDTH, default 8: sample width in bits.
REQ-002 Parameter DEPTH, default 16: history entries; SHALL be a power of two, at least 2.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 capture_en  input  1  when high, current_value is recorded this cycle.
REQ-006 current_value  input  WIDTH  sample to record.
REQ-007 replay_start  input  1  request replay of the most recent samples.
REQ-008 replay_len  input  $clog2(DEPTH)+1  requested sample count; 0 means "all stored".
REQ-009 out_valid  output  1  out_data holds a replay beat.
REQ-010 out_ready  input  1  consumer accepts the beat when high with out_valid.
REQ-011 out_data  output  WIDTH  replayed sample, oldest first.
REQ-012 out_last  output  1  high on the final beat of a replay.
REQ-013 busy  output  1  high while a replay is in progress.
REQ-014 count  output  $clog2(DEPTH)+1  number of valid stored samples, saturating at DEPTH.

Function
REQ-015 The block SHALL store samples in a circular buffer: on capture, write at wr_ptr, then wr_ptr wraps modulo DEPTH and count increments, saturating at DEPTH.
REQ-016 Once count equals DEPTH, each capture SHALL overwrite the oldest entry.
REQ-017 The state machine SHALL have two states: IDLE and PLAY.
REQ-018 capture_en SHALL be ignored while busy; the history is frozen during replay.
REQ-019 In IDLE, replay_start SHALL compute the effective length eff = (replay_len==0 || replay_len>count) ? count : replay_len.
REQ-020 If eff is 0, replay_start SHALL be a no-op and the block stays in IDLE.
REQ-021 If eff is nonzero, the block SHALL load rd_ptr = (wr_ptr - eff) mod DEPTH and beats_left = eff, then enter PLAY.
REQ-022 When replay_start and capture_en are both high in IDLE, the capture SHALL occur and the replay window SHALL be computed from the pre-capture wr_ptr and count (the new sample is excluded).
REQ-023 out_valid, out_data and out_last SHALL be registered; out_valid SHALL rise exactly one cycle after an accepted replay_start.
REQ-024 While out_valid is high and out_ready is low, out_data and out_last SHALL be held stable.
REQ-025 On each handshake, rd_ptr SHALL advance (wrapping at DEPTH) and beats_left SHALL decrement; the next beat is presented in the following cycle with no bubble.
REQ-026 out_last SHALL be high exactly when beats_left equals 1.
REQ-027 After the out_last handshake, the block SHALL return to IDLE; out_valid and busy SHALL be low the next cycle.
REQ-028 replay_start SHALL be ignored in PLAY.

Reset
REQ-029 rst_n low SHALL immediately clear: state to IDLE, wr_ptr, rd_ptr, beats_left, count, out_valid, out_last, busy, and out_data, all to 0.
REQ-030 Storage contents need not be reset; entries beyond count are never replayed.
REQ-031 A reset in PLAY SHALL abort the replay with no further beats.

Configuration
REQ-032 With macro HISTORY_REPLAY_CLEAR_EN defined, completing a replay (out_last handshake) SHALL set count to 0 (consume-on-read); wr_ptr is unchanged.
REQ-033 Without HISTORY_REPLAY_CLEAR_EN, the history and count SHALL be retained after a replay.

Structure
REQ-034 Package history_pkg SHALL hold the state enum (IDLE, PLAY) and a pointer-width helper constant/function based on $clog2(DEPTH).
REQ-035 Storage SHALL be a sub-module history_ram: DEPTH x WIDTH, one synchronous write port, one asynchronous read port.

Verification
REQ-036 Reset, capture 5,6,7 (WIDTH=8, DEPTH=16), replay_len=0, out_ready=1 -> beats 5,6,7 on consecutive cycles, out_last on 7, count=3.
REQ-037 Capture 1..20 -> count=16; replay_len=4 -> 17,18,19,20 (wrap path); replay_len=30 -> 5..20.
REQ-038 Replay of 3 with out_ready toggling 1,0,0,1,1 -> out_data held during stalls; exactly 3 handshakes, out_last only on third.
REQ-039 capture_en=1 with value 99 in the same cycle as replay_start (history 1,2) -> replay yields 1,2 only; count=3 afterwards (macro off); capture_en during PLAY -> count unchanged.
REQ-040 rst_n low mid-replay -> out_valid, busy, count=0 asynchronously; replay_start after reset with nothing captured -> no beats.
REQ-041 HISTORY_REPLAY_CLEAR_EN defined: capture 3, replay all -> count=0 after last beat; second replay_start -> no beats.
